// File: rtl/add_serial_if.sv
// ---------------------------------------------------------------------------
// add_serial_if
//
// Groups the add_serial operand/result handshake into one bundle.
//   master : the requester; drives start, a, b, ci (and sub) and reads
//            busy, done, s, co, ov.
//   slave  : the add_serial core; the opposite directions.
//
// Configuration macro: ADD_SERIAL_SUB_EN adds the sub (subtract select)
// signal to the bundle and to both modports.
//
// Parameter:
//   WIDTH : operand and result width; must match the core's WIDTH.
// ---------------------------------------------------------------------------
interface add_serial_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
`ifdef ADD_SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;

`ifdef ADD_SERIAL_SUB_EN
  modport master (output start, a, b, ci, sub, input busy, done, s, co, ov);
  modport slave  (input start, a, b, ci, sub, output busy, done, s, co, ov);
`else
  modport master (output start, a, b, ci, input busy, done, s, co, ov);
  modport slave  (input start, a, b, ci, output busy, done, s, co, ov);
`endif
endinterface : add_serial_if

// File: rtl/add_serial.sv
// ---------------------------------------------------------------------------
// add_serial
//
// Multi-cycle adder: a DIGIT-bit adder slice is iterated N = WIDTH/DIGIT
// times over WIDTH-bit operands, least significant digit first. Produces
// sum, carry-out and two's-complement overflow behind a start/done
// handshake.
//
// Configuration macro: ADD_SERIAL_SUB_EN enables subtract mode. With
// bus.sub=1 at the accepted start, B and the carry-in are inverted on
// entry (s = a - b - ci) and co reports the borrow-out.
//
// Ports:
//   clk   : clock, rising edge.
//   clrn  : synchronous active-low reset.
//   bus   : add_serial_if.slave
//             start      request, sampled in IDLE and DONE only
//             a, b, ci   operands, latched with an accepted start
//             sub        subtract select (ADD_SERIAL_SUB_EN only)
//             busy       high while the digits are being processed
//             done       one-cycle pulse, s/co/ov valid
//             s, co, ov  result, carry/borrow-out, signed overflow;
//                        held until the next accepted start
//
// Timing: start accepted at edge t -> digit steps on edges t+1..t+N ->
// done=1, busy=0 during the cycle after edge t+N. With start held high,
// a new operation is accepted in DONE, one result every N+1 cycles.
// ---------------------------------------------------------------------------
module add_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic        clk,
  input  logic        clrn,
  add_serial_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_params
    $error("add_serial: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] s_r;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sub_r;
  logic             busy_r;
  logic             done_r;
  logic             co_r;
  logic             ov_r;

  logic             sub_in;
  logic [DIGIT:0]   slice;
  logic             msb_cin;
  logic             last_step;
  logic [WIDTH-1:0] s_shift;

`ifdef ADD_SERIAL_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  // One digit of the addition. The carry into the slice MSB is recovered
  // from its sum bit, which gives the overflow on the final step without
  // splitting the slice adder.
  // NOTE: every always_comb output gets a value on every path; a missing
  // assignment would infer a latch.
  always_comb begin
    slice     = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};
    msb_cin   = slice[DIGIT-1] ^ a_r[DIGIT-1] ^ b_r[DIGIT-1];
    last_step = (cnt == CW'(N - 1));
  end

  // New digits enter at the top of s, so after N steps the first digit
  // has reached the bottom.
  if (N == 1) begin : g_shift_single
    assign s_shift = slice[DIGIT-1:0];
  end else begin : g_shift_multi
    assign s_shift = {slice[DIGIT-1:0], s_r[WIDTH-1:DIGIT]};
  end

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the operand shift registers and sub_r are not reset; they are
  // always loaded at an accepted start before being used.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      s_r    <= '0;
      co_r   <= 1'b0;
      ov_r   <= 1'b0;
      cnt    <= '0;
      carry  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= sub_in ? ~bus.b : bus.b;
            carry  <= sub_in ? ~bus.ci : bus.ci;
            sub_r  <= sub_in;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end

        RUN: begin
          a_r   <= a_r >> DIGIT;
          b_r   <= b_r >> DIGIT;
          s_r   <= s_shift;
          carry <= slice[DIGIT];
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            // In subtract mode the adder's final carry is "no borrow".
            co_r   <= slice[DIGIT] ^ sub_r;
            ov_r   <= slice[DIGIT] ^ msb_cin;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end

        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.s    = s_r;
  assign bus.co   = co_r;
  assign bus.ov   = ov_r;

endmodule : add_serial
